// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC vectoring unit.
// Contents: arctangent table, pi/2, 1/K shift-add list, FSM state type.
// Table values are atan(2^-i) scaled by 2^TAB_FRAC (Q3.23, i.e. WIDTH=24).
package cordic_pkg;

  localparam int TAB_FRAC = 23;
  localparam int DW       = TAB_FRAC + 3;

  // Padded to 32 entries so a 5-bit counter indexes it without range issues.
  localparam logic signed [DW-1:0] ATAN_TAB [32] = '{
    26'sd6588397, 26'sd3889358, 26'sd2055030, 26'sd1043165,
    26'sd523607,  26'sd262059,  26'sd131061,  26'sd65535,
    26'sd32768,   26'sd16384,   26'sd8192,    26'sd4096,
    26'sd2048,    26'sd1024,    26'sd512,     26'sd256,
    26'sd128,     26'sd64,      26'sd32,      26'sd16,
    26'sd8,       26'sd4,       26'sd2,       26'sd1,
    26'sd0,       26'sd0,       26'sd0,       26'sd0,
    26'sd0,       26'sd0,       26'sd0,       26'sd0
  };

  localparam logic signed [DW-1:0] PI_2 = 26'sd13176795;

  // 1/K ~= x/2 + x/8 - x/64 - x/512 - x/8192 - x/32768 - x/65536
  localparam int         GAIN_SHIFT [7] = '{1, 3, 6, 9, 13, 15, 16};
  localparam logic [6:0] GAIN_SUB       = 7'b1111100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_GAIN,
    ST_DONE
  } state_t;

  // Works on a sign-extended 32-bit copy; truncating back gives the same
  // low bits as doing the arithmetic at the native word width.
  function automatic logic signed [31:0] gain_comp(input logic signed [31:0] v);
    logic signed [31:0] acc;
    acc = '0;
    for (int k = 0; k < 7; k++) begin
      if (GAIN_SUB[k]) acc = acc - (v >>> GAIN_SHIFT[k]);
      else             acc = acc + (v >>> GAIN_SHIFT[k]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/cordic_vectoring_if.sv
// Request/result bundle of the CORDIC vectoring unit.
// master: drives start, x_in, y_in; receives busy, done, mag_out, ang_out.
// slave : the engine side.
interface cordic_vectoring_if #(
  parameter int DW = 26
);
  logic                 start;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] y_in;
  logic                 busy;
  logic                 done;
  logic signed [DW-1:0] mag_out;
  logic signed [DW-1:0] ang_out;

  modport master (output start, x_in, y_in, input busy, done, mag_out, ang_out);
  modport slave  (input start, x_in, y_in, output busy, done, mag_out, ang_out);
endinterface

// File: rtl/cordic_vector_stage.sv
// One combinational vectoring micro-rotation. Rotates toward y = 0,
// picking the direction from the sign of y (y = 0 counts as non-negative).
// Ports: i (shift), x/y/z (current), atan (table entry), x/y/z_next.
module cordic_vector_stage #(
  parameter int DW = 26
) (
  input  logic [4:0]           i,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  input  logic signed [DW-1:0] z,
  input  logic signed [DW-1:0] atan,
  output logic signed [DW-1:0] x_next,
  output logic signed [DW-1:0] y_next,
  output logic signed [DW-1:0] z_next
);
  logic signed [DW-1:0] x_sh;
  logic signed [DW-1:0] y_sh;
  logic                 y_neg;

  assign x_sh  = x >>> i;
  assign y_sh  = y >>> i;
  assign y_neg = y[DW-1];

  assign x_next = y_neg ? x - y_sh : x + y_sh;
  assign y_next = y_neg ? y + x_sh : y - x_sh;
  assign z_next = y_neg ? z - atan : z + atan;
endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring engine: returns magnitude and atan2(y, x) of
// a Cartesian input, one micro-rotation per clock.
// Ports: clk, reset (async, active high), io (slave side of
// cordic_vectoring_if: start/x_in/y_in in, busy/done/mag_out/ang_out out).
// Build option: define CORDIC_GAIN_COMP_EN to add a GAIN state that scales
// the magnitude by 1/K; otherwise mag_out is K-scaled (K ~= 1.646760).
//
// state | meaning
// IDLE  | waiting for start
// ITER  | one micro-rotation per edge, counter = shift index
// GAIN  | 1/K magnitude scaling (CORDIC_GAIN_COMP_EN only)
// DONE  | done high for one cycle; start here issues back-to-back
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH = 24,   // up to 24 (table precision)
  parameter int ITER  = 16    // 8..24
) (
  input  logic               clk,
  input  logic               reset,
  cordic_vectoring_if.slave  io
);
  localparam int         W    = WIDTH + 2;
  localparam int         ASH  = TAB_FRAC - (WIDTH - 1);
  localparam logic [4:0] LAST = 5'(ITER - 1);
  localparam logic signed [W-1:0] PI_2_W = W'(PI_2 >>> ASH);

  state_t              state;
  logic [4:0]          cnt;
  logic signed [W-1:0] x, y, z;
  logic signed [W-1:0] x_n, y_n, z_n;
  logic signed [W-1:0] atan_i;
  logic                busy_q, done_q;
  logic signed [W-1:0] mag_q, ang_q;

  assign atan_i = W'(ATAN_TAB[cnt] >>> ASH);

  cordic_vector_stage #(.DW(W)) u_stage (
    .i      (cnt),
    .x      (x),
    .y      (y),
    .z      (z),
    .atan   (atan_i),
    .x_next (x_n),
    .y_next (y_n),
    .z_next (z_n)
  );

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [W-1:0] x_comp;
  assign x_comp = W'(gain_comp(32'(x)));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mag_q  <= '0;
      ang_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (io.start) begin
            // Fold the left half-plane onto the right so the iterations
            // only have to cover +/- pi/2.
            if (!io.x_in[W-1]) begin
              x <= io.x_in;
              y <= io.y_in;
              z <= '0;
            end else if (!io.y_in[W-1]) begin
              x <= io.y_in;
              y <= -io.x_in;
              z <= PI_2_W;
            end else begin
              x <= -io.y_in;
              y <= io.x_in;
              z <= -PI_2_W;
            end
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_ITER;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ITER: begin
          x   <= x_n;
          y   <= y_n;
          z   <= z_n;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= ST_GAIN;
`else
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            mag_q  <= x_n;
            ang_q  <= z_n;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_GAIN: begin
          state  <= ST_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          mag_q  <= x_comp;
          ang_q  <= z;
        end
`endif
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.busy    = busy_q;
  assign io.done    = done_q;
  assign io.mag_out = mag_q;
  assign io.ang_out = ang_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
module tb_cordic_vectoring;
  localparam int WIDTH = 24;
  localparam int ITER  = 16;
  localparam int W     = WIDTH + 2;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 1;
`else
  localparam int LAT = ITER;
`endif
  localparam int TOL  = 256;
  localparam int ATOL = 320;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  cordic_vectoring_if #(.DW(W)) bus ();

  cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic int mag_exp(input int raw, input int comp);
`ifdef CORDIC_GAIN_COMP_EN
    return comp;
`else
    return raw;
`endif
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic issue(input int xv, input int yv);
    @(negedge clk);
    bus.x_in  = W'(xv);
    bus.y_in  = W'(yv);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.done && edges < 60);
  endtask

  initial begin
    int e;
    int nd;
    int first;

    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;

    #1 reset = 1'b1;
    #2;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_mag", bus.mag_out, 0);
    check_eq("rst_ang", bus.ang_out, 0);
    @(negedge clk);
    reset = 1'b0;

    // (0.5, 0.5)
    issue(4194304, 4194304);
    wait_done(e);
    check_eq("lat_q1", e, LAT);
    check_near("mag_q1", bus.mag_out, mag_exp(9768028, 5931642), TOL);
    check_near("ang_q1", bus.ang_out, 6588397, ATOL);

    // (-0.5, 0)
    issue(-4194304, 0);
    wait_done(e);
    check_eq("lat_neg_x", e, LAT);
    check_near("mag_neg_x", bus.mag_out, mag_exp(6907013, 4194304), TOL);
    check_near("ang_neg_x", bus.ang_out, 26353589, ATOL);

    // (0, -0.75)
    issue(0, -6291456);
    wait_done(e);
    check_eq("lat_neg_y", e, LAT);
    check_near("mag_neg_y", bus.mag_out, mag_exp(10360545, 6291456), TOL);
    check_near("ang_neg_y", bus.ang_out, -13176795, ATOL);

    // Back-to-back: start held through DONE with (-0.3, -0.4)
    issue(4194304, 4194304);
    wait_done(e);
    check_near("ang_b2b_first", bus.ang_out, 6588397, ATOL);
    bus.x_in  = W'(-2516582);
    bus.y_in  = W'(-3355443);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(e);
    check_eq("lat_b2b", e, LAT);
    check_near("ang_b2b", bus.ang_out, -18574960, ATOL);
    check_near("mag_b2b", bus.mag_out, mag_exp(6907013, 4194304), TOL);

    // Start pulses while busy must be ignored
    issue(0, -6291456);
    nd = 0;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 10 && (k % 2) == 0) begin
        bus.x_in  = W'(4194304);
        bus.y_in  = W'(4194304);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        nd++;
        if (first == 0) first = k;
      end
    end
    check_eq("ign_done_count", nd, 1);
    check_eq("ign_latency", first, LAT);
    check_near("ign_ang", bus.ang_out, -13176795, ATOL);
    check_near("ign_mag", bus.mag_out, mag_exp(10360545, 6291456), TOL);

    // Degenerate zero vector
    issue(0, 0);
    wait_done(e);
    check_eq("lat_zero", e, LAT);
    check_near("mag_zero", bus.mag_out, 0, 2);

    // (-1+LSB, 0) resolves to +pi
    issue(-8388607, 0);
    wait_done(e);
    check_near("ang_bnd", bus.ang_out, 26353589, ATOL);
    check_eq("ang_bnd_pos", int'(bus.ang_out > 0), 1);

    // Reset mid-run
    issue(4194304, 4194304);
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_done", bus.done, 0);
    check_eq("mid_rst_mag", bus.mag_out, 0);
    check_eq("mid_rst_ang", bus.ang_out, 0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    check_eq("mid_rst_no_done", nd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
